// File: rtl/csa_result_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : csa_result_accumulator
// Description : Sums COUNT consecutive {cout, sum} adder results per block and
//               presents each block total with a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module csa_result_accumulator #(
    parameter int WIDTH     = 32,
    parameter int ACC_WIDTH = 40,
    parameter int COUNT     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_sum,
    input  logic                 in_cout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_acc,
    output logic                 out_ovf
);

    localparam int CNT_W = $clog2(COUNT + 1);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(COUNT - 1);
    localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_ovf_sticky;
    logic [ACC_WIDTH-1:0] r_out_acc;
    logic                 r_out_ovf;

    logic [ACC_WIDTH-1:0] w_val;
    logic [ACC_WIDTH:0]   w_sum;
    logic                 w_in_fire;
    logic                 w_out_fire;
    logic                 w_last;

    // Handshake readiness is a pure state decode, never a function of in_valid.
    assign in_ready   = (r_state == ST_ACCUM);
    assign out_valid  = (r_state == ST_HOLD);
    assign out_acc    = r_out_acc;
    assign out_ovf    = r_out_ovf;

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign w_last     = (r_cnt == c_last);

    always_comb begin
        w_val            = '0;
        w_val[WIDTH:0]   = {in_cout, in_sum};
    end

    // Extra top bit captures the wrap past ACC_WIDTH for the overflow flag.
    assign w_sum = {1'b0, r_acc} + {1'b0, w_val};

    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = ST_ACCUM;
        end else begin
            case (r_state)
                ST_ACCUM: if (w_in_fire && w_last) w_state_next = ST_HOLD;
                ST_HOLD:  if (w_out_fire)          w_state_next = ST_ACCUM;
                default:                           w_state_next = ST_ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath only moves on an accepted input, so X on idle operands never lands in r_acc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_ovf_sticky <= 1'b0;
            r_out_acc    <= '0;
            r_out_ovf    <= 1'b0;
        end else if (clear) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_ovf_sticky <= 1'b0;
            r_out_ovf    <= 1'b0;
        end else if (w_in_fire) begin
            if (w_last) begin
                r_out_acc    <= w_sum[ACC_WIDTH-1:0];
                r_out_ovf    <= r_ovf_sticky | w_sum[ACC_WIDTH];
                r_acc        <= '0;
                r_cnt        <= '0;
                r_ovf_sticky <= 1'b0;
            end else begin
                r_acc        <= w_sum[ACC_WIDTH-1:0];
                r_ovf_sticky <= r_ovf_sticky | w_sum[ACC_WIDTH];
                r_cnt        <= r_cnt + c_one;
            end
        end
    end

endmodule
`default_nettype wire
